// File: rtl/pipe_regfile_pkg.sv
// pipe_regfile_pkg: register index constants and default sizes for the pipeline register file.
package pipe_regfile_pkg;
  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned DEF_NREGS = 32;
  localparam int unsigned REG_ZERO  = 0;
  localparam int unsigned REG_V0    = 2;
  localparam int unsigned REG_A0    = 4;
  localparam int unsigned REG_SP    = 29;
  localparam int unsigned REG_RA    = 31;
endpackage

// File: rtl/pipe_regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with same-edge bypass onto the registered read flags.
module regfile_scoreboard
  import pipe_regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_iss_en,
  input  logic [AW-1:0]     i_iss_addr,
  input  logic              i_wb_en,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD-1:0]    o_rd_busy
);
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;
  logic [NRD-1:0]   r_rd_busy;
  // issue is applied after writeback so a same-cycle new producer keeps the bit set
  always_comb begin
    w_busy_next = r_busy;
    if (i_wb_en) w_busy_next[i_wb_addr] = 1'b0;
    if (i_iss_en) w_busy_next[i_iss_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_busy <= '0;
    else r_busy <= w_busy_next;
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    always_ff @(posedge clk or posedge rst)
      if (rst) r_rd_busy[k] <= 1'b0;
      else r_rd_busy[k] <= w_busy_next[i_rd_addr[k*AW +: AW]];
  end
  assign o_rd_busy = r_rd_busy;
endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile: register file with writeback and link write ports, registered bypassed reads,
// and a busy scoreboard for pending destinations.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = 2,
  parameter int LINK_REG = 31,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic              link_en,
  input  logic [DW-1:0]     link_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [DW-1:0]     v0,
  output logic [DW-1:0]     a0,
  output logic [DW-1:0]     ra,
  output logic [DW-1:0]     sp
);
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  logic [DW-1:0] r_regs [NREGS];
  logic          w_wb_ok;
  logic          w_link_ok;
  assign w_wb_ok   = wb_en && (wb_addr != '0);
  assign w_link_ok = link_en && (LINK_A != '0);
  // link is written last so it wins a same-register conflict with writeback
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_wb_ok) r_regs[wb_addr] <= wb_data;
      if (w_link_ok) r_regs[LINK_A] <= link_data;
    end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_val;
    logic [DW-1:0] r_data;
    assign w_addr = rd_addr[k*AW +: AW];
    assign w_val  = (w_addr == '0) ? '0 :
                    (w_link_ok && w_addr == LINK_A) ? link_data :
                    (w_wb_ok && w_addr == wb_addr) ? wb_data : r_regs[w_addr];
    always_ff @(posedge clk or posedge rst)
      if (rst) r_data <= '0;
      else r_data <= w_val;
    assign rd_data[k*DW +: DW] = r_data;
  end
  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .AW(AW)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_iss_en  (iss_en),
    .i_iss_addr(iss_addr),
    .i_wb_en   (wb_en),
    .i_wb_addr (wb_addr),
    .i_rd_addr (rd_addr),
    .o_rd_busy (rd_busy)
  );
  assign v0 = r_regs[AW'(REG_V0)];
  assign a0 = r_regs[AW'(REG_A0)];
  assign ra = r_regs[AW'(REG_RA)];
  assign sp = r_regs[AW'(REG_SP)];
endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed checks of writes, bypass, link priority, reg0, scoreboard and async reset.
module tb_pipe_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        link_en = 1'b0;
  logic [31:0] link_data = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [31:0] v0, a0, ra, sp;
  int errors = 0;
  int checks = 0;

  pipe_regfile #(.DW(32), .NREGS(32), .NRD(2), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .link_en(link_en), .link_data(link_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .v0(v0), .a0(a0), .ra(ra), .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b0; link_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
    rd_addr = {p1, p0};
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_rd0", rd_data[31:0], 32'h0);
    chk("rst_busy", {30'b0, rd_busy}, 32'h0);
    chk("rst_ra", ra, 32'h0);
    #1 rst = 1'b0;
    // write then read next cycle
    wb(5'd5, 32'hDEADBEEF);
    tick();
    chk("rd0_addr0", rd_data[31:0], 32'h0);
    idle(); rd(5'd5, 5'd0);
    tick();
    chk("wr_then_rd", rd_data[31:0], 32'hDEADBEEF);
    // same-edge bypass
    wb(5'd7, 32'h12345678); rd(5'd5, 5'd7);
    tick();
    chk("bypass_rd1", rd_data[63:32], 32'h12345678);
    chk("storage_rd0", rd_data[31:0], 32'hDEADBEEF);
    // wb vs link conflict on reg 31
    idle(); wb(5'd31, 32'h1111); link_en = 1'b1; link_data = 32'h2222; rd(5'd31, 5'd31);
    tick();
    chk("conflict_ra", ra, 32'h2222);
    chk("conflict_rd0", rd_data[31:0], 32'h2222);
    chk("conflict_rd1", rd_data[63:32], 32'h2222);
    // register 0 ignores writes and issues
    idle(); wb(5'd0, 32'hFFFFFFFF); iss_en = 1'b1; iss_addr = 5'd0; rd(5'd0, 5'd0);
    tick();
    chk("zero_bypass", rd_data[31:0], 32'h0);
    chk("zero_busy", {30'b0, rd_busy}, 32'h0);
    idle();
    tick();
    chk("zero_storage", rd_data[63:32], 32'h0);
    chk("zero_busy2", {30'b0, rd_busy}, 32'h0);
    // scoreboard on reg 9
    iss_en = 1'b1; iss_addr = 5'd9; rd(5'd9, 5'd7);
    tick();
    chk("sb_issue", {30'b0, rd_busy}, 32'h1);
    wb(5'd9, 32'hAA); iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    chk("sb_iss_wb", {30'b0, rd_busy}, 32'h1);
    chk("sb_iss_wb_data", rd_data[31:0], 32'hAA);
    idle(); wb(5'd9, 32'hBB);
    tick();
    chk("sb_wb_clear", {30'b0, rd_busy}, 32'h0);
    chk("sb_wb_data", rd_data[31:0], 32'hBB);
    // link leaves busy untouched
    idle(); iss_en = 1'b1; iss_addr = 5'd31; rd(5'd0, 5'd31);
    tick();
    chk("sb_iss31", {30'b0, rd_busy}, 32'h2);
    idle(); link_en = 1'b1; link_data = 32'h3333;
    tick();
    chk("sb_link_keeps", {30'b0, rd_busy}, 32'h2);
    chk("link_rd1", rd_data[63:32], 32'h3333);
    // architectural taps
    idle(); wb(5'd2, 32'h22);
    tick();
    chk("tap_v0", v0, 32'h22);
    wb(5'd4, 32'h44);
    tick();
    chk("tap_a0", a0, 32'h44);
    wb(5'd29, 32'h2929);
    tick();
    chk("tap_sp", sp, 32'h2929);
    chk("tap_ra", ra, 32'h3333);
    // mid-run async reset with a pending write
    idle(); wb(5'd5, 32'h55); rd(5'd31, 5'd5);
    #2 rst = 1'b1;
    #1;
    chk("mrst_rd0", rd_data[31:0], 32'h0);
    chk("mrst_rd1", rd_data[63:32], 32'h0);
    chk("mrst_busy", {30'b0, rd_busy}, 32'h0);
    chk("mrst_v0", v0, 32'h0);
    chk("mrst_a0", a0, 32'h0);
    chk("mrst_ra", ra, 32'h0);
    chk("mrst_sp", sp, 32'h0);
    tick();
    idle(); rst = 1'b0;
    wb(5'd6, 32'h66); iss_en = 1'b1; iss_addr = 5'd6; rd(5'd6, 5'd5);
    tick();
    chk("post_rst_wr", rd_data[31:0], 32'h66);
    chk("post_rst_busy", {30'b0, rd_busy}, 32'h1);
    chk("discarded_wr", rd_data[63:32], 32'h0);
    idle(); rd(5'd31, 5'd9);
    tick();
    chk("post_rst_ra", rd_data[31:0], 32'h0);
    chk("post_rst_r9", rd_data[63:32], 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
